// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM state encoding,
// the full-word byte-enable constant and the partial-write lane merge.
package dm_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RMW_WR = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

    localparam logic [3:0] BE_FULL  = 4'b1111;
    localparam logic [3:0] BE_EMPTY = 4'b0000;

    // Per byte lane: take the write data where enabled, otherwise keep the stored byte.
    function automatic logic [31:0] merge_lanes(input logic [3:0]  be,
                                                input logic [31:0] wdata,
                                                input logic [31:0] rdata);
        logic [31:0] merged;
        merged = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_arb2.sv
// Combinational two-way pick. On a tie the port that did not win last time is
// chosen, unless fixed priority is selected, in which case port 0 always wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic prio_mode,
    output logic winner,
    output logic valid
);

    // Winner selection; winner is only meaningful while valid is high.
    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = prio_mode ? 1'b0 : ~last_grant;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single-port word data memory between the CPU (port 0) and the
// DMA/loader (port 1); partial writes are carried out as read-modify-write.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [3:0]  be0,
    input  logic [3:0]  be1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        busy,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic PRIO_BIT = (PRIO_MODE != 0);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        busy_q, busy_d;

    logic        winner_s, valid_s;
    logic        sel_we_s;
    logic [3:0]  sel_be_s;
    logic [31:0] sel_addr_s, sel_wdata_s;
    logic        addr_lsb_unused_s;

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .prio_mode  (PRIO_BIT),
        .winner     (winner_s),
        .valid      (valid_s)
    );

    assign sel_we_s          = winner_s ? we1    : we0;
    assign sel_be_s          = winner_s ? be1    : be0;
    assign sel_addr_s        = winner_s ? addr1  : addr0;
    assign sel_wdata_s       = winner_s ? wdata1 : wdata0;
    // Memory is word-addressed; the byte offset only matters through be.
    assign addr_lsb_unused_s = ^{addr0[1:0], addr1[1:0]};

    // Next-state and next-output logic; every output is a flop.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        be_d         = be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        gnt0_d       = gnt0_q;
        gnt1_d       = gnt1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_s) begin
                    owner_d      = winner_s;
                    last_grant_d = winner_s;
                    we_d         = sel_we_s;
                    be_d         = sel_be_s;
                    mem_addr_d   = {sel_addr_s[31:2], 2'b00};
                    mem_wdata_d  = sel_wdata_s;
                    mem_we_d     = sel_we_s && (sel_be_s == BE_FULL);
                    gnt0_d       = ~winner_s;
                    gnt1_d       = winner_s;
                    state_d      = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    if (owner_q) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = ST_ACK;
                end else if ((be_q == BE_FULL) || (be_q == BE_EMPTY)) begin
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = ST_ACK;
                end else begin
                    mem_wdata_d = merge_lanes(be_q, mem_wdata_q, mem_rdata);
                    mem_we_d    = 1'b1;
                    state_d     = ST_RMW_WR;
                end
            end
            ST_RMW_WR: begin
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers; reset low drops any in-flight RMW write and ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            mem_we_q     <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= 32'h0000_0000;
            rdata1_q     <= 32'h0000_0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            be_q         <= be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign busy      = busy_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench: two arbiters (round-robin and fixed priority) share the
// requester stimulus, each with its own 16-word memory model.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [3:0]  be0, be1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic        gnt0_a, gnt1_a, ack0_a, ack1_a, busy_a, mem_we_a;
    logic [31:0] rdata0_a, rdata1_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        gnt0_b, gnt1_b, ack0_b, ack1_b, busy_b, mem_we_b;
    logic [31:0] rdata0_b, rdata1_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    logic [31:0] mem_a [0:15];
    logic [31:0] mem_b [0:15];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.PRIO_MODE(0)) u_dut_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .ack0(ack0_a), .ack1(ack1_a),
        .rdata0(rdata0_a), .rdata1(rdata1_a), .busy(busy_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    dm_port_arbiter #(.PRIO_MODE(1)) u_dut_b (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .ack0(ack0_b), .ack1(ack1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b), .busy(busy_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    assign mem_rdata_a = mem_a[mem_addr_a[5:2]];
    assign mem_rdata_b = mem_b[mem_addr_b[5:2]];

    // Memory models: bench preload has precedence over DUT writes.
    always @(posedge clk) begin
        if (pl_en) begin
            mem_a[pl_idx] <= pl_val;
            mem_b[pl_idx] <= pl_val;
        end else begin
            if (mem_we_a) mem_a[mem_addr_a[5:2]] <= mem_wdata_a;
            if (mem_we_b) mem_b[mem_addr_b[5:2]] <= mem_wdata_b;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        step();
        pl_en = 1'b0;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        be0 = 4'b0000; be1 = 4'b0000;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0010;
        step(); step();
        checks++;
        if ({gnt0_a, gnt1_a, ack0_a, ack1_a, mem_we_a, busy_a} !== 6'b000000) begin
            errors++; $display("FAIL reset_outs_a: got %b want 000000", {gnt0_a, gnt1_a, ack0_a, ack1_a, mem_we_a, busy_a});
        end
        checks++;
        if ({gnt0_b, gnt1_b, ack0_b, ack1_b, mem_we_b, busy_b} !== 6'b000000) begin
            errors++; $display("FAIL reset_outs_b: got %b want 000000", {gnt0_b, gnt1_b, ack0_b, ack1_b, mem_we_b, busy_b});
        end
        checks++;
        if (rdata0_a !== 32'h0 || rdata1_a !== 32'h0 || mem_addr_a !== 32'h0) begin
            errors++; $display("FAIL reset_regs: rdata0 %h rdata1 %h mem_addr %h want 0", rdata0_a, rdata1_a, mem_addr_a);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({gnt0_a, gnt1_a, busy_a} !== 3'b101) begin
            errors++; $display("FAIL reset_release_grant: got gnt0,gnt1,busy=%b want 101", {gnt0_a, gnt1_a, busy_a});
        end
        step();
        req0 = 1'b0;
        step();
    endtask

    task automatic test_read();
        preload(4'd4, 32'hA1B2C3D4);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0010;
        step();
        checks++;
        if ({gnt0_a, ack0_a, mem_we_a} !== 3'b100 || mem_addr_a !== 32'h0000_0010) begin
            errors++; $display("FAIL read_access: gnt0,ack0,we=%b addr=%h want 100 00000010", {gnt0_a, ack0_a, mem_we_a}, mem_addr_a);
        end
        step();
        checks++;
        if ({ack0_a, ack1_a, mem_we_a} !== 3'b100) begin
            errors++; $display("FAIL read_ack: ack0,ack1,we=%b want 100", {ack0_a, ack1_a, mem_we_a});
        end
        checks++;
        if (rdata0_a !== 32'hA1B2C3D4) begin
            errors++; $display("FAIL read_data: got %h want a1b2c3d4", rdata0_a);
        end
        req0 = 1'b0;
        step();
        checks++;
        if ({ack0_a, busy_a, mem_we_a} !== 3'b000 || rdata0_a !== 32'hA1B2C3D4) begin
            errors++; $display("FAIL read_after: ack0,busy,we=%b rdata0=%h want 000 a1b2c3d4", {ack0_a, busy_a, mem_we_a}, rdata0_a);
        end
    endtask

    task automatic test_partial_write();
        preload(4'd8, 32'h11223344);
        req1 = 1'b1; we1 = 1'b1; be1 = 4'b0010; addr1 = 32'h0000_0020; wdata1 = 32'h0000EE00;
        step();
        checks++;
        if ({gnt0_a, gnt1_a, mem_we_a, ack1_a} !== 4'b0100) begin
            errors++; $display("FAIL pw_access: gnt0,gnt1,we,ack1=%b want 0100", {gnt0_a, gnt1_a, mem_we_a, ack1_a});
        end
        step();
        checks++;
        if (mem_we_a !== 1'b1 || mem_wdata_a !== 32'h1122EE44 || ack1_a !== 1'b0 || mem_addr_a !== 32'h20) begin
            errors++; $display("FAIL pw_rmw: we=%b wdata=%h ack1=%b addr=%h want 1 1122ee44 0 00000020", mem_we_a, mem_wdata_a, ack1_a, mem_addr_a);
        end
        step();
        checks++;
        if ({ack1_a, ack0_a, mem_we_a} !== 3'b100 || mem_a[8] !== 32'h1122EE44) begin
            errors++; $display("FAIL pw_ack: ack1,ack0,we=%b mem=%h want 100 1122ee44", {ack1_a, ack0_a, mem_we_a}, mem_a[8]);
        end
        req1 = 1'b0; we1 = 1'b0; be1 = 4'b0000;
        step();
        checks++;
        if (busy_a !== 1'b0 || gnt1_a !== 1'b0) begin
            errors++; $display("FAIL pw_idle: busy=%b gnt1=%b want 0 0", busy_a, gnt1_a);
        end
    endtask

    task automatic test_full_write();
        req0 = 1'b1; we0 = 1'b1; be0 = 4'b1111; addr0 = 32'h0000_000C; wdata0 = 32'hDEADBEEF;
        step();
        checks++;
        if (mem_we_a !== 1'b1 || mem_wdata_a !== 32'hDEADBEEF || ack0_a !== 1'b0) begin
            errors++; $display("FAIL fw_access: we=%b wdata=%h ack0=%b want 1 deadbeef 0", mem_we_a, mem_wdata_a, ack0_a);
        end
        step();
        checks++;
        if (ack0_a !== 1'b1 || mem_we_a !== 1'b0 || mem_a[3] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fw_ack: ack0=%b we=%b mem=%h want 1 0 deadbeef", ack0_a, mem_we_a, mem_a[3]);
        end
        req0 = 1'b0; we0 = 1'b0; be0 = 4'b0000;
        step();
    endtask

    task automatic test_contention_rr();
        int n = 0;
        int cyc = 0;
        preload(4'd5, 32'h55667788);
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0014;
        step(); step();
        reset = 1'b1;
        while (n < 8 && cyc < 60) begin
            step();
            cyc++;
            checks++;
            if (gnt0_a && gnt1_a) begin
                errors++; $display("FAIL rr_one_gnt: both grants high at cycle %0d", cyc);
            end
            if (ack0_a || ack1_a) begin
                checks++;
                if ({ack1_a, ack0_a} !== ((n % 2 == 1) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rr_order: ack %0d got {ack1,ack0}=%b want %b", n, {ack1_a, ack0_a}, (n % 2 == 1) ? 2'b10 : 2'b01);
                end
                checks++;
                if ((ack0_a && rdata0_a !== 32'hA1B2C3D4) || (ack1_a && rdata1_a !== 32'h55667788)) begin
                    errors++; $display("FAIL rr_rdata: rdata0=%h rdata1=%h want a1b2c3d4 55667788", rdata0_a, rdata1_a);
                end
                n++;
            end
        end
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL rr_timeout: got %0d acks want 8", n);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_prio_fixed();
        int n = 0;
        int cyc = 0;
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0014;
        step(); step();
        reset = 1'b1;
        while (n < 4 && cyc < 60) begin
            step();
            cyc++;
            if (ack0_b || ack1_b) begin
                checks++;
                if ({ack1_b, ack0_b} !== ((n == 3) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL prio_order: ack %0d got {ack1,ack0}=%b want %b", n, {ack1_b, ack0_b}, (n == 3) ? 2'b10 : 2'b01);
                end
                n++;
                if (n == 3) req0 = 1'b0;
            end
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL prio_timeout: got %0d acks want 4", n);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_rmw();
        preload(4'd2, 32'hCAFEF00D);
        req0 = 1'b1; we0 = 1'b1; be0 = 4'b0011; addr0 = 32'h0000_0008; wdata0 = 32'h00001234;
        step();
        checks++;
        if (gnt0_a !== 1'b1 || mem_we_a !== 1'b0) begin
            errors++; $display("FAIL rst_mid_access: gnt0=%b we=%b want 1 0", gnt0_a, mem_we_a);
        end
        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; be0 = 4'b0000;
        step();
        checks++;
        if ({busy_a, gnt0_a, ack0_a, mem_we_a} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_idle: busy,gnt0,ack0,we=%b want 0000", {busy_a, gnt0_a, ack0_a, mem_we_a});
        end
        reset = 1'b1;
        step();
        checks++;
        if ({busy_a, ack0_a, mem_we_a} !== 3'b000 || mem_a[2] !== 32'hCAFEF00D || mem_b[2] !== 32'hCAFEF00D) begin
            errors++; $display("FAIL rst_mid_mem: busy,ack0,we=%b mem_a=%h mem_b=%h want 000 cafef00d", {busy_a, ack0_a, mem_we_a}, mem_a[2], mem_b[2]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pl_en = 1'b0; pl_idx = 4'd0; pl_val = 32'h0;
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_read();
        test_partial_write();
        test_full_write();
        test_contention_rr();
        test_prio_fixed();
        test_reset_mid_rmw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
